// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit: FSM states,
// opcodes, control-word field codes and trap causes.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;

   localparam logic [3:0] ALUOP_LOAD   = 4'd0;
   localparam logic [3:0] ALUOP_OP_IMM = 4'd1;
   localparam logic [3:0] ALUOP_AUIPC  = 4'd2;
   localparam logic [3:0] ALUOP_STORE  = 4'd3;
   localparam logic [3:0] ALUOP_OP     = 4'd4;
   localparam logic [3:0] ALUOP_LUI    = 4'd5;
   localparam logic [3:0] ALUOP_BRANCH = 4'd6;
   localparam logic [3:0] ALUOP_JALR   = 4'd7;
   localparam logic [3:0] ALUOP_JAL    = 4'd8;

   localparam logic [2:0] M2R_ALU  = 3'b000;
   localparam logic [2:0] M2R_LOAD = 3'b001;
   localparam logic [2:0] M2R_IMM  = 3'b010;
   localparam logic [2:0] M2R_BADR = 3'b011;
   localparam logic [2:0] M2R_PC4  = 3'b100;

   localparam logic [1:0] SRC_RS2   = 2'b00;
   localparam logic [1:0] SRC_IMM   = 2'b01;
   localparam logic [1:0] SRC_SHAMT = 2'b10;

   localparam logic [1:0] JMP_NONE = 2'b00;
   localparam logic [1:0] JMP_JALR = 2'b01;
   localparam logic [1:0] JMP_JAL  = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_IMEM    = 2'b10;
   localparam logic [1:0] CAUSE_DMEM    = 2'b11;

   typedef struct packed {
      logic [3:0] alu_op;
      logic [2:0] mem_to_reg;
      logic [1:0] alu_src;
      logic [1:0] jump;
      logic       is_load;
      logic       is_store;
      logic       is_branch;
   } cw_t;

   localparam int CW_W = $bits(cw_t);

   function automatic logic is_shift(input logic [2:0] funct);
      return (funct == 3'b001) || (funct == 3'b101);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decode into the control word plus an illegal-opcode flag.
// Illegal opcodes yield an all-zero control word so a NOP retire leaves nothing enabled.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct,
   output logic [CW_W-1:0] cw,
   output logic            illegal
);

   cw_t d;

   always_comb begin
      d       = '0;
      illegal = 1'b0;
      case (opcode)
         OPC_LOAD: begin
            d.alu_op     = ALUOP_LOAD;
            d.mem_to_reg = M2R_LOAD;
            d.alu_src    = SRC_IMM;
            d.is_load    = 1'b1;
         end
         OPC_OP_IMM: begin
            d.alu_op  = ALUOP_OP_IMM;
            d.alu_src = is_shift(funct) ? SRC_SHAMT : SRC_IMM;
         end
         OPC_AUIPC: begin
            d.alu_op     = ALUOP_AUIPC;
            d.mem_to_reg = M2R_BADR;
            d.alu_src    = SRC_IMM;
         end
         OPC_STORE: begin
            d.alu_op   = ALUOP_STORE;
            d.alu_src  = SRC_IMM;
            d.is_store = 1'b1;
         end
         OPC_OP: begin
            d.alu_op = ALUOP_OP;
         end
         OPC_LUI: begin
            d.alu_op     = ALUOP_LUI;
            d.mem_to_reg = M2R_IMM;
            d.alu_src    = SRC_IMM;
         end
         OPC_BRANCH: begin
            d.alu_op    = ALUOP_BRANCH;
            d.is_branch = 1'b1;
         end
         OPC_JALR: begin
            d.alu_op     = ALUOP_JALR;
            d.mem_to_reg = M2R_PC4;
            d.alu_src    = SRC_IMM;
            d.jump       = JMP_JALR;
         end
         OPC_JAL: begin
            d.alu_op     = ALUOP_JAL;
            d.mem_to_reg = M2R_PC4;
            d.jump       = JMP_JAL;
         end
         default: illegal = 1'b1;
      endcase
   end

   assign cw = d;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM with variable-latency memory handshakes and trapping.
// Optional retired-instruction counter built only when CTRL_PERF_CNT_EN is defined.
module multicycle_control_unit
   import ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter bit ILLEGAL_TRAP   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        ir_load,
   output logic        pc_write,
   output logic        cntl_MemWrite,
   output logic        cntl_RegWrite,
   output logic        cntl_Branch,
   output logic [2:0]  sel_MemToReg,
   output logic [1:0]  sel_ALUSrc,
   output logic [1:0]  sel_jump,
   output logic [3:0]  ALUOp,
   output logic [2:0]  state,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [31:0] instret
);

   localparam int WC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WC_W-1:0] WC_LAST = WC_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t            state_q, state_n;
   cw_t               cw_q, dec_cw;
   logic [CW_W-1:0]   dec_raw;
   logic              dec_illegal;
   logic [1:0]        cause_q, cause_n;
   logic [WC_W-1:0]   wait_cnt;
   logic              timed_out;

   ctrl_decode u_decode (
      .opcode  (opcode),
      .funct   (funct),
      .cw      (dec_raw),
      .illegal (dec_illegal)
   );

   assign dec_cw = cw_t'(dec_raw);

   // Fires on the last permitted wait cycle; a ready in that same cycle takes priority.
   assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt == WC_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_FETCH;
         cw_q     <= '0;
         cause_q  <= CAUSE_NONE;
         wait_cnt <= '0;
      end else begin
         state_q <= state_n;
         if (state_q == S_DECODE)
            cw_q <= dec_cw;
         if (state_q != S_TRAP && state_n == S_TRAP)
            cause_q <= cause_n;
         if (state_n != state_q)
            wait_cnt <= '0;
         else if (state_q == S_FETCH || state_q == S_MEM)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_comb begin
      state_n       = state_q;
      cause_n       = CAUSE_NONE;
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      ir_load       = 1'b0;
      pc_write      = 1'b0;
      cntl_MemWrite = 1'b0;
      cntl_RegWrite = 1'b0;
      cntl_Branch   = 1'b0;
      // Requests must fall the moment reset asserts, not at the next edge.
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_load = 1'b1;
                  state_n = S_DECODE;
               end else if (timed_out) begin
                  state_n = S_TRAP;
                  cause_n = CAUSE_IMEM;
               end
            end
            S_DECODE: begin
               if (!dec_illegal) begin
                  state_n = S_EXEC;
               end else if (ILLEGAL_TRAP) begin
                  state_n = S_TRAP;
                  cause_n = CAUSE_ILLEGAL;
               end else begin
                  pc_write = 1'b1;
                  state_n  = S_FETCH;
               end
            end
            S_EXEC: begin
               if (cw_q.is_load || cw_q.is_store) begin
                  state_n = S_MEM;
               end else if (cw_q.is_branch) begin
                  cntl_Branch = 1'b1;
                  pc_write    = 1'b1;
                  state_n     = S_FETCH;
               end else begin
                  state_n = S_WB;
               end
            end
            S_MEM: begin
               dmem_req      = 1'b1;
               cntl_MemWrite = cw_q.is_store;
               if (dmem_ready) begin
                  if (cw_q.is_store) begin
                     pc_write = 1'b1;
                     state_n  = S_FETCH;
                  end else begin
                     state_n = S_WB;
                  end
               end else if (timed_out) begin
                  state_n = S_TRAP;
                  cause_n = CAUSE_DMEM;
               end
            end
            S_WB: begin
               cntl_RegWrite = 1'b1;
               pc_write      = 1'b1;
               state_n       = S_FETCH;
            end
            S_TRAP: state_n = S_TRAP;
            default: state_n = S_FETCH;
         endcase
      end
   end

   assign ALUOp        = cw_q.alu_op;
   assign sel_MemToReg = cw_q.mem_to_reg;
   assign sel_ALUSrc   = cw_q.alu_src;
   assign sel_jump     = cw_q.jump;
   assign state        = state_q;
   assign trap         = (state_q == S_TRAP);
   assign trap_cause   = cause_q;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] instret_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         instret_q <= '0;
      else if (pc_write)
         instret_q <= instret_q + 32'd1;
   end

   assign instret = instret_q;
`else
   assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each issued instruction pushes its expected retire/trap record,
// an independent monitor closes a record on every pc_write or trap entry and compares.
module tb_multicycle_control_unit;
   import ctrl_pkg::*;

   localparam int TO = 4;

   logic        clk, rst;
   logic [6:0]  opcode;
   logic [2:0]  funct;
   logic        imem_ready, dmem_ready;
   logic        imem_req, dmem_req, ir_load, pc_write;
   logic        cntl_MemWrite, cntl_RegWrite, cntl_Branch;
   logic [2:0]  sel_MemToReg;
   logic [1:0]  sel_ALUSrc, sel_jump;
   logic [3:0]  ALUOp;
   logic [2:0]  state;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [31:0] instret;

   multicycle_control_unit #(.TIMEOUT_CYCLES(TO), .ILLEGAL_TRAP(1'b1)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .ir_load(ir_load), .pc_write(pc_write),
      .cntl_MemWrite(cntl_MemWrite), .cntl_RegWrite(cntl_RegWrite), .cntl_Branch(cntl_Branch),
      .sel_MemToReg(sel_MemToReg), .sel_ALUSrc(sel_ALUSrc), .sel_jump(sel_jump),
      .ALUOp(ALUOp), .state(state), .trap(trap), .trap_cause(trap_cause), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int is_trap, cycles, cause;
      int alu_op, m2r, src, jmp;
      int rw, br, mw, dq, bad, ild;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0, errors = 0;
   int issued = 0, done_cnt = 0, model_ret = 0;
   int iw_cur = 0, dw_cur = 0;
   logic [6:0] legal_ops [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: instruction class tables and cycle budgets straight from the behavioural rules.
   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f, input int iw, input int dw);
      exp_t e;
      bit   mem, legal;
      e = '{default: 0};
      mem   = (op == 7'h03) || (op == 7'h23);
      legal = 1'b1;
      case (op)
         7'h03: begin e.alu_op = 0; e.m2r = 1; e.src = 1; end
         7'h13: begin e.alu_op = 1; e.src = (f == 3'd1 || f == 3'd5) ? 2 : 1; end
         7'h17: begin e.alu_op = 2; e.m2r = 3; e.src = 1; end
         7'h23: begin e.alu_op = 3; e.src = 1; end
         7'h33: begin e.alu_op = 4; end
         7'h37: begin e.alu_op = 5; e.m2r = 2; e.src = 1; end
         7'h63: begin e.alu_op = 6; end
         7'h67: begin e.alu_op = 7; e.m2r = 4; e.src = 1; e.jmp = 1; end
         7'h6F: begin e.alu_op = 8; e.m2r = 4; e.jmp = 2; end
         default: legal = 1'b0;
      endcase
      if (iw >= TO) begin
         e.is_trap = 1; e.cause = 2; e.cycles = TO + 1;
      end else if (!legal) begin
         e.is_trap = 1; e.cause = 1; e.cycles = iw + 3;
      end else if (mem && dw >= TO) begin
         e.is_trap = 1; e.cause = 3; e.cycles = iw + TO + 4;
      end else begin
         e.cycles = iw + ((op == 7'h63) ? 3 : (op == 7'h03) ? 5 : 4) + (mem ? dw : 0);
         e.rw  = (op == 7'h23 || op == 7'h63) ? 0 : 1;
         e.br  = (op == 7'h63) ? 1 : 0;
         e.mw  = (op == 7'h23) ? dw + 1 : 0;
         e.dq  = mem ? dw + 1 : 0;
         e.ild = 1;
      end
      return e;
   endfunction

   // Memory responders: assert ready after the requested number of wait cycles.
   initial begin : responder
      int ic, dc;
      ic = 0; dc = 0;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      forever begin
         @(posedge clk); #2;
         if (imem_req) begin imem_ready = (ic == iw_cur); ic++; end
         else begin imem_ready = 1'b0; ic = 0; end
         if (dmem_req) begin dmem_ready = (dc == dw_cur); dc++; end
         else begin dmem_ready = 1'b0; dc = 0; end
      end
   end

   initial begin : monitor
      int   cyc, rw, br, mw, dq, bad, ild;
      bit   prev_trap;
      exp_t e;
      cyc = 0; rw = 0; br = 0; mw = 0; dq = 0; bad = 0; ild = 0; prev_trap = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            cyc = 0; rw = 0; br = 0; mw = 0; dq = 0; bad = 0; ild = 0; prev_trap = 1'b0;
         end else begin
            cyc++;
            rw  += int'(cntl_RegWrite);
            br  += int'(cntl_Branch);
            mw  += int'(cntl_MemWrite);
            dq  += int'(dmem_req);
            ild += int'(ir_load);
            bad += int'(cntl_MemWrite && !dmem_req);
            if (pc_write || (trap && !prev_trap)) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_event: got pc_write=%0d trap=%0d expected no event", pc_write, trap);
               end else begin
                  e = exp_q.pop_front();
                  chk("is_trap", 32'(trap), e.is_trap);
                  chk("cycles", cyc, e.cycles);
                  if (e.is_trap != 0) begin
                     chk("trap_cause", 32'(trap_cause), e.cause);
                     chk("trap_enables", 32'({imem_req, dmem_req, ir_load, pc_write,
                         cntl_MemWrite, cntl_RegWrite, cntl_Branch}), 0);
                  end else begin
                     chk("ALUOp", 32'(ALUOp), e.alu_op);
                     chk("sel_MemToReg", 32'(sel_MemToReg), e.m2r);
                     chk("sel_ALUSrc", 32'(sel_ALUSrc), e.src);
                     chk("sel_jump", 32'(sel_jump), e.jmp);
                     chk("regwrite_cycles", rw, e.rw);
                     chk("branch_cycles", br, e.br);
                     chk("memwrite_cycles", mw, e.mw);
                     chk("dmem_req_cycles", dq, e.dq);
                     chk("memwrite_unqualified", bad, e.bad);
                     chk("ir_load_cycles", ild, e.ild);
                  end
               end
               done_cnt++;
               cyc = 0; rw = 0; br = 0; mw = 0; dq = 0; bad = 0; ild = 0;
            end
            prev_trap = trap;
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      done_cnt  = issued;
      model_ret = 0;
      iw_cur = 0; dw_cur = 0;
      rst = 1'b0;
   endtask

   // Called one time unit after the edge that enters FETCH; returns likewise.
   task automatic issue(input logic [6:0] op, input logic [2:0] f, input int iw, input int dw);
      exp_t e;
      e = model(op, f, iw, dw);
      exp_q.push_back(e);
      issued++;
      if (e.is_trap == 0) model_ret++;
      opcode = op; funct = f; iw_cur = iw; dw_cur = dw;
      for (int k = 0; k < 300 && done_cnt < issued; k++) @(posedge clk);
      #1;
      if (done_cnt < issued) begin
         checks++; errors++;
         $display("FAIL completion_timeout: got no retire/trap for opcode %0h expected one within 300 cycles", op);
         do_reset();
      end
   endtask

   task automatic post_trap_check(input logic [1:0] cause);
      repeat (3) @(posedge clk);
      #1;
      chk("trap_sticky", 32'(trap), 1);
      chk("trap_cause_sticky", 32'(trap_cause), 32'(cause));
      chk("trap_state", 32'(state), 32'(S_TRAP));
      chk("trap_quiet", 32'({imem_req, dmem_req, ir_load, pc_write,
          cntl_MemWrite, cntl_RegWrite, cntl_Branch}), 0);
   endtask

   task automatic check_outputs_idle(input string tag);
      chk({tag, "_state"}, 32'(state), 32'(S_FETCH));
      chk({tag, "_enables"}, 32'({imem_req, dmem_req, ir_load, pc_write,
          cntl_MemWrite, cntl_RegWrite, cntl_Branch, trap}), 0);
      chk({tag, "_sels"}, 32'({sel_MemToReg, sel_ALUSrc, sel_jump, ALUOp, trap_cause}), 0);
      chk({tag, "_instret"}, instret, 0);
   endtask

   initial begin : stimulus
      bit found;
      rst = 1'b1; opcode = '0; funct = '0;
      #3;
      check_outputs_idle("reset");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      issue(7'h13, 3'd0, 0, 0);   // ADDI zero-wait
      issue(7'h03, 3'd2, 0, 3);   // LW, data delayed 3 cycles
      issue(7'h23, 3'd2, 0, 2);   // SW with MEM wait
      issue(7'h63, 3'd0, 0, 0);   // BEQ
      issue(7'h13, 3'd1, 3, 0);   // SLLI, fetch ready on the timeout cycle
      issue(7'h13, 3'd5, 0, 0);
      issue(7'h03, 3'd0, 1, 3);   // load ready on the timeout cycle
      issue(7'h6F, 3'd0, 0, 0);
      issue(7'h67, 3'd0, 0, 0);
      issue(7'h37, 3'd0, 0, 0);
      issue(7'h17, 3'd0, 0, 0);
      issue(7'h33, 3'd0, 0, 0);
      for (int n = 0; n < 50; n++)
         issue(legal_ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
               $urandom_range(0, 3), $urandom_range(0, 3));
`ifdef CTRL_PERF_CNT_EN
      chk("instret_run", instret, model_ret);
`else
      chk("instret_run", instret, 0);
`endif

      issue(7'h7F, 3'd0, 1, 0);
      post_trap_check(2'b01);
      do_reset();
      issue(7'h13, 3'd0, 255, 0);
      post_trap_check(2'b10);
      do_reset();
      issue(7'h03, 3'd0, 1, 255);
      post_trap_check(2'b11);
      do_reset();

      // Abort a load in its MEM wait with an asynchronous reset.
      opcode = 7'h03; funct = 3'd2; iw_cur = 0; dw_cur = 255;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk); #3;
         found = dmem_req;
      end
      chk("reach_mem", 32'(found), 1);
      rst = 1'b1;
      #1;
      check_outputs_idle("rst_mid_mem");
      @(posedge clk); #1;
      model_ret = 0; dw_cur = 0;
      rst = 1'b0;

      for (int n = 0; n < 10; n++)
         issue(legal_ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
               $urandom_range(0, 2), $urandom_range(0, 2));
`ifdef CTRL_PERF_CNT_EN
      chk("instret_ten", instret, 10);
`else
      chk("instret_ten", instret, 0);
`endif
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
